uart_rx_core: RTL

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_3ff.sv | 28 ++
 rtl/uart_rx_core.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: Rx state encoding, synchronizer depth, default frame geometry.
// No logic, so no latency and no backpressure.
package uart_pkg;

    localparam int NUMBER_OF_RX_SYNCHRONIZERS = 3;
    localparam int DEFAULT_INPUT_DATA_WIDTH   = 8;
    localparam int DEFAULT_CLOCKS_PER_BIT     = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        WAIT_IDLE  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_sync_3ff.sv
// Flop-chain synchronizer for one asynchronous line; reset value is a parameter.
// Latency NUMBER_OF_RX_SYNCHRONIZERS clk; no backpressure.
module uart_sync_3ff
    import uart_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    localparam int N = NUMBER_OF_RX_SYNCHRONIZERS;

    logic [N-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {N{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[N-2:0], i_async};
        end
    end

    assign o_sync = r_sync[N-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronized line, mid-bit sampling, parity and framing checks.
// Latency 86 clk from start edge at defaults; no backpressure, results are one-cycle pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH = DEFAULT_INPUT_DATA_WIDTH,
    parameter int PARITY_ENABLED   = 1,
    parameter int PARITY_TYPE      = 0,
    parameter int CLOCKS_PER_BIT   = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        o_busy
);

    localparam int TIMER_W = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int IDX_W   = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

    // Start sample sits one edge ahead of the half-bit count so every later
    // mid-bit sample, and the stop decision, lands on the fixed output latency.
    localparam logic [TIMER_W-1:0] START_SAMPLE = TIMER_W'(CLOCKS_PER_BIT / 2 - 2);
    localparam logic [TIMER_W-1:0] MID_SAMPLE   = TIMER_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(INPUT_DATA_WIDTH - 1);
    localparam logic               PARITY_ODD   = (PARITY_TYPE != 0);

    logic                        w_rx_s;
    logic                        w_mid;
    rx_state_t                   r_state;
    logic [TIMER_W-1:0]          r_timer;
    logic [IDX_W-1:0]            r_bit_idx;
    logic [INPUT_DATA_WIDTH-1:0] r_shift;
    logic                        r_parity_err;
    logic [INPUT_DATA_WIDTH-1:0] r_data;
    logic                        r_data_vld;
    logic                        r_err;
    logic                        r_busy;

    uart_sync_3ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (serial_in),
        .o_sync  (w_rx_s)
    );

    assign w_mid = (r_timer == MID_SAMPLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_parity_err <= 1'b0;
            r_data       <= '0;
            r_data_vld   <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_vld <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START_BIT;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (r_timer == START_SAMPLE) begin
                        r_timer <= '0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state      <= DATA_BIT;
                            r_bit_idx    <= '0;
                            r_parity_err <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                DATA_BIT: begin
                    if (w_mid) begin
                        r_timer <= '0;
                        r_shift <= {w_rx_s, r_shift[INPUT_DATA_WIDTH-1:1]};
                        if (r_bit_idx == LAST_IDX) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY_ENABLED != 0) ? PARITY_BIT : STOP_BIT;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                PARITY_BIT: begin
                    if (w_mid) begin
                        r_timer      <= '0;
                        r_parity_err <= w_rx_s ^ (^r_shift) ^ PARITY_ODD;
                        r_state      <= STOP_BIT;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                STOP_BIT: begin
                    if (w_mid) begin
                        r_timer <= '0;
                        if (w_rx_s) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            if (r_parity_err) begin
                                r_err <= 1'b1;
                            end else begin
                                r_data     <= r_shift;
                                r_data_vld <= 1'b1;
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= WAIT_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign received_data = r_data;
    assign data_is_valid = r_data_vld;
    assign rx_error      = r_err;
    assign o_busy        = r_busy;

endmodule
